// File: rtl/adjust_button_ctrl.sv
// adjust_button_ctrl: front-panel adjust controller that turns three raw push-buttons into field-select and up/down strobes.
// Latency: a clean raw edge sampled at edge k acts at edge k+DEBOUNCE_CYCLES+3 (2 sync, debounce, 1 edge register).
// Backpressure: none; strobes are fire-and-forget single-cycle pulses to the field counters.
// Ports: clk/rst_n (async active-low); btn_mode/btn_up/btn_down raw async buttons;
//        adj_sel one-hot field enable (0 in RUN); adj_up/adj_down one-cycle strobes; adjusting high outside RUN.
module adjust_button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_PERIOD   = 100000,
  parameter int TIMEOUT_CYCLES  = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [5:0] adj_sel,
  output logic       adj_up,
  output logic       adj_down,
  output logic       adjusting
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam int IDLE_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0]  DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0]  PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST   = IDLE_W'(TIMEOUT_CYCLES - 1);

  localparam int B_MODE = 0;
  localparam int B_UP   = 1;
  localparam int B_DOWN = 2;

  typedef enum logic [2:0] {
    S_RUN, S_SEC, S_MIN, S_HOUR, S_DAY, S_MON, S_YEAR
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronisers, debouncers and rising-edge press pulses
  // ---------------------------------------------------------------------------
  logic [2:0]      raw;
  logic [2:0]      sync1;
  logic [2:0]      sync2;
  logic [2:0]      db;
  logic [2:0]      db_nxt;
  logic [2:0]      db_dly;
  logic [2:0]      press;
  logic [DB_W-1:0] db_cnt     [3];
  logic [DB_W-1:0] db_cnt_nxt [3];

  assign raw = {btn_down, btn_up, btn_mode};

  // The counter runs only while the synchronised level disagrees with db;
  // any agreeing cycle restarts the stability window.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      db_nxt[i]     = db[i];
      db_cnt_nxt[i] = '0;
      if (sync2[i] != db[i]) begin
        if (db_cnt[i] == DB_LAST) begin
          db_nxt[i] = sync2[i];
        end else begin
          db_cnt_nxt[i] = db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      db     <= '0;
      db_dly <= '0;
      press  <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      db     <= db_nxt;
      db_dly <= db;
      press  <= db & ~db_dly;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= db_cnt_nxt[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Field FSM, auto-repeat and idle timeout
  // ---------------------------------------------------------------------------
  state_t           state;
  state_t           state_adv;
  logic             rpt_armed;
  logic             rpt_dir_up;
  logic             rpt_first;
  logic [RPT_W-1:0] rpt_cnt;
  logic [IDLE_W-1:0] idle_cnt;

  // Hold status uses the level db takes on this edge, so a repeat pulse that
  // falls due on the very edge db drops is suppressed.
  logic hold_up;
  logic hold_dn;
  logic hold_both;
  logic rpt_hold;
  logic rpt_due;
  logic press_up_ok;
  logic press_dn_ok;
  logic rpt_fire;

  function automatic state_t advance(input state_t s);
    case (s)
      S_RUN:   return S_SEC;
      S_SEC:   return S_MIN;
      S_MIN:   return S_HOUR;
      S_HOUR:  return S_DAY;
      S_DAY:   return S_MON;
      S_MON:   return S_YEAR;
      default: return S_RUN;
    endcase
  endfunction

  function automatic logic [5:0] sel_code(input state_t s);
    case (s)
      S_SEC:   return 6'b000001;
      S_MIN:   return 6'b000010;
      S_HOUR:  return 6'b000100;
      S_DAY:   return 6'b001000;
      S_MON:   return 6'b010000;
      S_YEAR:  return 6'b100000;
      default: return 6'b000000;
    endcase
  endfunction

  assign state_adv   = advance(state);
  assign hold_up     = db_nxt[B_UP];
  assign hold_dn     = db_nxt[B_DOWN];
  assign hold_both   = hold_up & hold_dn;
  assign rpt_hold    = rpt_dir_up ? hold_up : hold_dn;
  assign rpt_due     = rpt_first ? (rpt_cnt == DELAY_LAST) : (rpt_cnt == PERIOD_LAST);
  assign press_up_ok = press[B_UP] & hold_up & ~hold_dn;
  assign press_dn_ok = press[B_DOWN] & hold_dn & ~hold_up;
  assign rpt_fire    = rpt_armed & ~hold_both & ~press_up_ok & ~press_dn_ok & rpt_hold & rpt_due;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RUN;
      adj_sel    <= '0;
      adj_up     <= 1'b0;
      adj_down   <= 1'b0;
      adjusting  <= 1'b0;
      rpt_armed  <= 1'b0;
      rpt_dir_up <= 1'b0;
      rpt_first  <= 1'b0;
      rpt_cnt    <= '0;
      idle_cnt   <= '0;
    end else begin
      adj_up   <= 1'b0;
      adj_down <= 1'b0;
      if (press[B_MODE]) begin
        // Mode wins over any coincident up/down; the new field needs a fresh press.
        state     <= state_adv;
        adj_sel   <= sel_code(state_adv);
        adjusting <= (state_adv != S_RUN);
        rpt_armed <= 1'b0;
        rpt_cnt   <= '0;
        idle_cnt  <= '0;
      end else if (state == S_RUN) begin
        rpt_armed <= 1'b0;
        rpt_cnt   <= '0;
        idle_cnt  <= '0;
      end else begin
        if (hold_both) begin
          rpt_armed <= 1'b0;
          rpt_cnt   <= '0;
        end else if (press_up_ok) begin
          adj_up     <= 1'b1;
          rpt_armed  <= 1'b1;
          rpt_dir_up <= 1'b1;
          rpt_first  <= 1'b1;
          rpt_cnt    <= '0;
        end else if (press_dn_ok) begin
          adj_down   <= 1'b1;
          rpt_armed  <= 1'b1;
          rpt_dir_up <= 1'b0;
          rpt_first  <= 1'b1;
          rpt_cnt    <= '0;
        end else if (rpt_armed && !rpt_hold) begin
          rpt_armed <= 1'b0;
          rpt_cnt   <= '0;
        end else if (rpt_fire) begin
          adj_up    <= rpt_dir_up;
          adj_down  <= ~rpt_dir_up;
          rpt_first <= 1'b0;
          rpt_cnt   <= '0;
        end else if (rpt_armed) begin
          rpt_cnt <= rpt_cnt + RPT_W'(1);
        end

        // Any up/down press or repeat pulse counts as activity.
        if (press[B_UP] || press[B_DOWN] || rpt_fire) begin
          idle_cnt <= '0;
        end else if (idle_cnt == IDLE_LAST) begin
          state     <= S_RUN;
          adj_sel   <= '0;
          adjusting <= 1'b0;
          rpt_armed <= 1'b0;
          rpt_cnt   <= '0;
          idle_cnt  <= '0;
        end else begin
          idle_cnt <= idle_cnt + IDLE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_adjust_button_ctrl.sv
// tb_adjust_button_ctrl: directed scenarios plus random button traffic against a timestamp-based reference model.
// A scoreboard queue holds expected (cycle, up, down, sel) events; a negedge monitor pops and compares them.
// Small parameters: DEBOUNCE 4, REPEAT_DELAY 16, REPEAT_PERIOD 4, TIMEOUT 64.
module tb_adjust_button_ctrl;

  localparam int DB = 4;
  localparam int RD = 16;
  localparam int RP = 4;
  localparam int TO = 64;

  logic       clk;
  logic       rst_n;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic [5:0] adj_sel;
  logic       adj_up;
  logic       adj_down;
  logic       adjusting;

  adjust_button_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_mode (btn_mode),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .adj_sel  (adj_sel),
    .adj_up   (adj_up),
    .adj_down (adj_down),
    .adjusting(adjusting)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic       up;
    logic       dn;
    logic [5:0] sel;
  } ev_t;

  ev_t exp_q [$];
  int  n_tests;
  int  n_fail;
  int  cyc;
  int  cur_field;

  // ---------------------------------------------------------------------------
  // Reference model: levels tracked by the time a disagreement started,
  // repeats and timeout by absolute due times.
  // ---------------------------------------------------------------------------
  bit         m_hist1 [3];
  bit         m_hist2 [3];
  bit         m_lvl   [3];
  int         m_diff_from [3];
  int         m_rise_at   [3];
  int         m_field;
  int         m_last_act;
  int         m_next_due;
  int         m_armed;       // 0 none, 1 up, 2 down (doubles as button index)
  logic [5:0] m_prev_sel;

  function automatic logic [5:0] field_sel(input int f);
    logic [5:0] s;
    s = '0;
    if (f != 0) s[f-1] = 1'b1;
    return s;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      m_hist1[b]     = 1'b0;
      m_hist2[b]     = 1'b0;
      m_lvl[b]       = 1'b0;
      m_diff_from[b] = -1;
      m_rise_at[b]   = -100;
    end
    m_field    = 0;
    m_last_act = 0;
    m_next_due = 0;
    m_armed    = 0;
    m_prev_sel = '0;
  endtask

  task automatic model_step();
    bit         raw [3];
    bit         ev  [3];
    bit         seen;
    bit         pu;
    bit         pd;
    bit         act;
    logic [5:0] sel;
    ev_t        e;
    raw[0] = btn_mode;
    raw[1] = btn_up;
    raw[2] = btn_down;
    for (int b = 0; b < 3; b++) begin
      ev[b] = (m_rise_at[b] == cyc - 2);
      seen = m_hist2[b];
      m_hist2[b] = m_hist1[b];
      m_hist1[b] = raw[b];
      if (seen != m_lvl[b]) begin
        if (m_diff_from[b] < 0) m_diff_from[b] = cyc;
        if (cyc - m_diff_from[b] + 1 >= DB) begin
          m_lvl[b] = seen;
          m_diff_from[b] = -1;
          if (seen) m_rise_at[b] = cyc;
        end
      end else begin
        m_diff_from[b] = -1;
      end
    end
    pu = 1'b0;
    pd = 1'b0;
    act = 1'b0;
    if (ev[0]) begin
      m_field = (m_field + 1) % 7;
      m_armed = 0;
      m_last_act = cyc;
    end else if (m_field != 0) begin
      if (ev[1] || ev[2]) act = 1'b1;
      if (m_lvl[1] && m_lvl[2]) begin
        m_armed = 0;
      end else if (ev[1] && m_lvl[1]) begin
        pu = 1'b1;
        m_armed = 1;
        m_next_due = cyc + RD;
      end else if (ev[2] && m_lvl[2]) begin
        pd = 1'b1;
        m_armed = 2;
        m_next_due = cyc + RD;
      end else if (m_armed != 0) begin
        if (!m_lvl[m_armed]) begin
          m_armed = 0;
        end else if (cyc == m_next_due) begin
          pu = (m_armed == 1);
          pd = (m_armed == 2);
          m_next_due = cyc + RP;
          act = 1'b1;
        end
      end
      if (act) begin
        m_last_act = cyc;
      end else if (cyc - m_last_act >= TO) begin
        m_field = 0;
        m_armed = 0;
      end
    end else begin
      m_armed = 0;
    end
    sel = field_sel(m_field);
    if (pu || pd || sel != m_prev_sel) begin
      e.t = cyc;
      e.up = pu;
      e.dn = pd;
      e.sel = sel;
      exp_q.push_back(e);
    end
    m_prev_sel = sel;
  endtask

  initial begin
    cyc = 0;
    model_reset();
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: every DUT output event is matched against the queue head.
  // ---------------------------------------------------------------------------
  initial begin
    logic [5:0] prev_sel;
    ev_t        e;
    prev_sel = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_sel = '0;
      end else begin
        while (exp_q.size() > 0 && exp_q[0].t < cyc) begin
          e = exp_q.pop_front();
          n_tests++;
          n_fail++;
          $display("FAIL sb_missed cyc=%0d: no DUT event, expected up=%b dn=%b sel=%b at cyc %0d",
                   cyc, e.up, e.dn, e.sel, e.t);
        end
        if (adj_up || adj_down || adj_sel != prev_sel) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected cyc=%0d: got up=%b dn=%b sel=%b, expected no event",
                     cyc, adj_up, adj_down, adj_sel);
          end else begin
            e = exp_q.pop_front();
            if (e.t != cyc || e.up !== adj_up || e.dn !== adj_down || e.sel !== adj_sel) begin
              n_fail++;
              $display("FAIL sb_event cyc=%0d: got up=%b dn=%b sel=%b, expected up=%b dn=%b sel=%b at cyc %0d",
                       cyc, adj_up, adj_down, adj_sel, e.up, e.dn, e.sel, e.t);
            end
          end
          n_tests++;
          if ((adj_up && adj_down) || ((adj_up || adj_down) && adj_sel == 6'd0)) begin
            n_fail++;
            $display("FAIL strobe_rules cyc=%0d: got up=%b dn=%b sel=%b", cyc, adj_up, adj_down, adj_sel);
          end
          n_tests++;
          if (adjusting !== (adj_sel != 6'd0)) begin
            n_fail++;
            $display("FAIL adjusting_flag cyc=%0d: got %b with sel=%b", cyc, adjusting, adj_sel);
          end
          prev_sel = adj_sel;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    tick(8);
    btn_mode = 1'b0;
    tick(10);
    cur_field = (cur_field + 1) % 7;
  endtask

  task automatic goto_field(input int f);
    while (cur_field != f) press_mode();
  endtask

  logic [5:0] step_tbl [7] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000,
                               6'b010000, 6'b100000, 6'b000000};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int ups;
    int dns;
    int t_rise;
    int t_seen;
    int t0;
    int t1;
    int t_first;
    int t_second;
    n_tests = 0;
    n_fail = 0;
    cur_field = 0;
    rst_n = 1'b0;
    btn_mode = 1'b0;
    btn_up = 1'b0;
    btn_down = 1'b0;
    tick(3);
    check("reset_sel", adj_sel, 0);
    check("reset_up", adj_up, 0);
    check("reset_down", adj_down, 0);
    check("reset_adjusting", adjusting, 0);
    rst_n = 1'b1;
    tick(3);

    // Step through every field and back to RUN.
    for (int i = 0; i < 7; i++) begin
      press_mode();
      check("step_sel", adj_sel, step_tbl[i]);
      check("step_adjusting", adjusting, (i < 6) ? 1 : 0);
    end

    // Bounce rejection in DAY: only the final clean rise counts.
    goto_field(4);
    for (int i = 0; i < 5; i++) begin
      btn_up = 1'b1;
      tick(2);
      btn_up = 1'b0;
      tick(2);
    end
    btn_up = 1'b1;
    t_rise = cyc + 1;
    ups = 0;
    t_seen = -1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (i == 12) btn_up = 1'b0;
      if (adj_up) begin
        ups++;
        t_seen = cyc;
      end
    end
    check("bounce_pulses", ups, 1);
    check("bounce_latency", t_seen - t_rise, 7);
    tick(10);

    // Auto-repeat in MIN. Release lands so db falls exactly when the pulse
    // at +48 would be due, which must be suppressed.
    goto_field(2);
    btn_up = 1'b1;
    t_first = -1;
    for (int i = 0; i < 30 && t_first < 0; i++) begin
      tick(1);
      if (adj_up) t_first = cyc;
    end
    check("repeat_press_seen", (t_first >= 0) ? 1 : 0, 1);
    ups = 1;
    dns = 0;
    t_second = -1;
    for (int i = 1; i <= 60; i++) begin
      tick(1);
      if (i == 42) btn_up = 1'b0;
      if (adj_up) begin
        ups++;
        if (t_second < 0) t_second = cyc;
      end
      if (adj_down) dns++;
    end
    check("repeat_pulses", ups, 9);
    check("repeat_first_gap", t_second - t_first, 16);
    check("repeat_no_down", dns, 0);
    tick(10);

    // RUN ignores down presses.
    goto_field(0);
    btn_down = 1'b1;
    dns = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (adj_down || adj_up) dns++;
    end
    btn_down = 1'b0;
    check("run_gating", dns, 0);
    tick(12);

    // HOUR with up and down held together: no strobes at all.
    goto_field(3);
    btn_up = 1'b1;
    btn_down = 1'b1;
    ups = 0;
    for (int i = 0; i < 24; i++) begin
      tick(1);
      if (adj_up || adj_down) ups++;
    end
    btn_up = 1'b0;
    btn_down = 1'b0;
    check("conflict_pulses", ups, 0);
    tick(10);

    // Mode and up rise together in SEC: field advances, up dropped, no repeat.
    goto_field(1);
    btn_mode = 1'b1;
    btn_up = 1'b1;
    ups = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (i == 8) btn_mode = 1'b0;
      if (adj_up) ups++;
    end
    check("mode_wins_sel", adj_sel, 6'b000010);
    check("mode_wins_no_up", ups, 0);
    cur_field = 2;
    btn_up = 1'b0;
    tick(12);

    // Timeout from YEAR with no activity.
    goto_field(5);
    btn_mode = 1'b1;
    t0 = -1;
    for (int i = 0; i < 40 && t0 < 0; i++) begin
      tick(1);
      if (adj_sel == 6'b100000) t0 = cyc;
    end
    btn_mode = 1'b0;
    t1 = -1;
    for (int i = 0; i < 200 && t1 < 0; i++) begin
      tick(1);
      if (adj_sel == 6'b000000) t1 = cyc;
    end
    check("timeout_cycles", t1 - t0, TO);
    check("timeout_adjusting", adjusting, 0);
    cur_field = 0;
    tick(5);

    // Async reset in the middle of an auto-repeat.
    goto_field(1);
    btn_up = 1'b1;
    ups = 0;
    for (int i = 0; i < 80 && ups < 2; i++) begin
      @(posedge clk);
      #1;
      if (adj_up) ups++;
    end
    check("rst_repeat_reached", ups, 2);
    rst_n = 1'b0;
    #1;
    check("rst_async_up", adj_up, 0);
    check("rst_async_sel", adj_sel, 0);
    check("rst_async_adjusting", adjusting, 0);
    exp_q.delete();
    btn_up = 1'b0;
    tick(3);
    rst_n = 1'b1;
    cur_field = 0;
    tick(5);

    // Random button traffic, checked entirely by the scoreboard.
    for (int i = 0; i < 150; i++) begin
      btn_mode = ($urandom_range(0, 5) == 0);
      btn_up   = ($urandom_range(0, 2) == 0);
      btn_down = ($urandom_range(0, 3) == 0);
      tick($urandom_range(1, 24));
      if ($urandom_range(0, 9) == 0) begin
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        tick(70);
      end
    end
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    tick(120);
    check("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
